memory_access_unit: RTL
=======================

Name: memory_access_unit

Overview:
- Sits directly downstream of the control unit.
- Accepts one memory request at a time (instruction fetch, load or store) and runs it as a single Wishbone-classic transfer on the external bus.
- Returns aligned, sign/zero-extended load data together with completion and error strobes.
- Owns byte-lane steering, byte selects and misalignment detection; the control unit only supplies operation, address, funct3 and store data.

Parameters:
- TIMEOUT_CYCLES, 255, maximum bus-wait cycles before a forced error (used only with MAU_TIMEOUT_EN).
- ADDR_W, 32, address width driven onto the bus.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- memory_operation  in  memory_operation_t  MEM_NONE / FETCH_DATA / LOAD_DATA / STORE_DATA.
- cyc  in  1  request valid from control unit.
- ack  out  1  one-cycle pulse: request accepted and latched.
- done  out  1  one-cycle pulse: transfer finished (any operation).
- data_valid  out  1  one-cycle pulse with done for FETCH_DATA / LOAD_DATA success.
- err  out  1  one-cycle pulse on misalignment, bus error or timeout; done is not pulsed.
- funct3_cu  in  3  access width/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB/SH/SW same low bits).
- address  in  ADDR_W  byte address (PC for fetch, ALU result for load/store).
- store_data  in  32  rs2 value, right-justified.
- fetched_data  out  32  extended load/fetch result; held until the next successful read.
- wb_adr_o  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}).
- wb_dat_o  out  32  lane-steered store data.
- wb_dat_i  in  32  bus read data.
- wb_sel_o  out  4  byte enables.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  bus strobe.
- wb_ack_i  in  1  bus acknowledge.
- wb_err_i  in  1  bus error.

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE.
  - ack, done, data_valid, err, wb_cyc_o, wb_stb_o, wb_we_o = 0.
  - wb_sel_o = 0; wb_adr_o, wb_dat_o, fetched_data = 0.
  - An in-flight bus cycle is abandoned with no strobe to the control unit.
- FSM states: IDLE, CHECK, BUS, RESP.
- IDLE:
  - On cyc=1 and memory_operation!=MEM_NONE: latch op, funct3, address and store_data; pulse ack for one cycle; go to CHECK.
  - The control unit may drop cyc after ack.
  - cyc with MEM_NONE is ignored.
- CHECK (1 cycle):
  - FETCH always uses a word access regardless of funct3.
  - Misaligned if halfword with addr[0]=1, or word with addr[1:0]!=0. Misaligned → pulse err, no bus cycle, go to IDLE.
  - Otherwise drive wb_adr_o, wb_sel_o, wb_we_o (STORE only), wb_cyc_o=wb_stb_o=1; go to BUS.
- Byte selects:
  - byte access: 4'b0001<<addr[1:0].
  - halfword access: 4'b0011<<addr[1:0] (addr[1] selects 0011 or 1100).
  - word access: 4'b1111.
- Store data replication: byte → {4{d[7:0]}}; half → {2{d[15:0]}}; word → d.
- BUS:
  - Hold all bus outputs stable.
  - wb_ack_i=1: drop cyc/stb/we the next edge; reads capture wb_dat_i; go to RESP.
  - wb_err_i=1, or ack and err together (err wins): drop bus, pulse err, go to IDLE; fetched_data unchanged.
- RESP (1 cycle):
  - Reads: shift the captured word right by addr[1:0]*8, then extend. LB/LH sign-extend; LBU/LHU zero-extend; LW/FETCH pass through.
  - Reads load fetched_data and pulse data_valid and done together.
  - Stores pulse done only.
  - Go to IDLE.
- Latency, ack to done with zero-wait-state slave: 3 cycles (CHECK, BUS, RESP). Each slave wait state adds 1 cycle.
- New requests are accepted only in IDLE. cyc held high in other states is ignored, and a new request cannot be accepted in the cycle done is pulsed.
- Strobes are exactly one clk wide and mutually exclusive, except that data_valid coincides with done.

Optional Feature:
- Macro MAU_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to BUS and increments each BUS cycle.
  - When the count reaches TIMEOUT_CYCLES with no ack or err: drop the bus, pulse err, return to IDLE.
  - An ack arriving on the same cycle as the timeout is honoured, not timed out.
- Not defined: no counter; BUS waits indefinitely.

Test Plan:
- FETCH_DATA, addr 0x00000010, slave returns 0x00A00093 with 0 wait states → ack pulse; wb_sel 1111, we=0; 3 cycles later done=data_valid=1 and fetched_data=0x00A00093.
- LOAD LB addr 0x103, wb_dat_i 0x80FF_1234 → wb_sel 1000, wb_adr 0x100, fetched_data 0xFFFFFF80. Repeat with LBU → 0x00000080.
- STORE SH addr 0x202, store_data 0x0000BEEF → wb_sel 1100, wb_dat_o 0xBEEFBEEF, we=1; done pulses, data_valid stays 0.
- LOAD LW addr 0x101 → err pulse 1 cycle after ack, wb_cyc never asserted, fetched_data unchanged.
- LOAD LW with slave asserting wb_err_i after 2 waits → err pulse, no done. With MAU_TIMEOUT_EN, TIMEOUT_CYCLES=4 and a silent slave → err after 4 BUS cycles.
- rst driven low mid-BUS (asynchronously, between edges) → wb_cyc/stb drop immediately, no strobes; a subsequent FETCH completes normally.

Source files
------------

// File: rtl/memory_access_unit.sv
// Memory access unit: runs one Wishbone-classic transfer per control-unit request,
// with byte-lane steering, misalignment detection and load extension. Optional bus timeout: MAU_TIMEOUT_EN.
package memory_access_unit_pkg;
    typedef enum logic [1:0] {
        MEM_NONE   = 2'd0,
        FETCH_DATA = 2'd1,
        LOAD_DATA  = 2'd2,
        STORE_DATA = 2'd3
    } memory_operation_t;
endpackage

// state | meaning
// IDLE  | waiting for a request from the control unit
// CHECK | alignment check, bus outputs prepared
// BUS   | Wishbone cycle in flight, waiting for ack/err
// RESP  | read data aligned/extended, completion strobed
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  memory_operation_t memory_operation,
    input  logic              cyc,
    output logic              ack,
    output logic              done,
    output logic              data_valid,
    output logic              err,
    input  logic [2:0]        funct3_cu,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       store_data,
    output logic [31:0]       fetched_data,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    output logic [3:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BUS, S_RESP} state_t;

    state_t            state_q, state_d;
    memory_operation_t op_q, op_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d, adr_q, adr_d;
    logic [31:0]       sdata_q, sdata_d, rdata_q, rdata_d;
    logic [31:0]       fetched_q, fetched_d, dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              ack_q, ack_d, done_q, done_d, dv_q, dv_d, err_q, err_d;
    logic              bcyc_q, bcyc_d, we_q, we_d;

    logic              accept, timeout, bus_fail;
    logic              is_byte, is_half, misaligned;
    logic [3:0]        sel_calc;
    logic [31:0]       wdat_calc, shifted, rd_ext;

`ifdef MAU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // an ack on the terminal cycle wins over the timeout
    assign timeout = !wb_ack_i && !wb_err_i && ((cnt_q + 1'b1) == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // a new request is never taken in the cycle done is being pulsed
    assign accept   = cyc && (memory_operation != MEM_NONE) && !done_q;
    assign bus_fail = wb_err_i || timeout;

    always_comb begin
        is_byte    = (op_q != FETCH_DATA) && (f3_q[1:0] == 2'b00);
        is_half    = (op_q != FETCH_DATA) && (f3_q[1:0] == 2'b01);
        misaligned = (is_half && addr_q[0]) || (!is_byte && !is_half && (addr_q[1:0] != 2'b00));
        shifted    = rdata_q >> {addr_q[1:0], 3'b000};
        if (is_byte) begin
            sel_calc  = 4'b0001 << addr_q[1:0];
            wdat_calc = {4{sdata_q[7:0]}};
            rd_ext    = f3_q[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            sel_calc  = addr_q[1] ? 4'b1100 : 4'b0011;
            wdat_calc = {2{sdata_q[15:0]}};
            rd_ext    = f3_q[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        end else begin
            sel_calc  = 4'b1111;
            wdat_calc = sdata_q;
            rd_ext    = shifted;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CHECK;
            S_CHECK: state_d = misaligned ? S_IDLE : S_BUS;
            S_BUS: begin
                if (bus_fail)      state_d = S_IDLE;
                else if (wb_ack_i) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d      = op_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        sdata_d   = sdata_q;
        rdata_d   = rdata_q;
        fetched_d = fetched_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        bcyc_d    = bcyc_q;
        ack_d     = 1'b0;
        done_d    = 1'b0;
        dv_d      = 1'b0;
        err_d     = 1'b0;
`ifdef MAU_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = memory_operation;
                    f3_d    = funct3_cu;
                    addr_d  = address;
                    sdata_d = store_data;
                    ack_d   = 1'b1;
                end
            end
            S_CHECK: begin
                if (misaligned) begin
                    err_d = 1'b1;
                end else begin
                    adr_d  = {addr_q[ADDR_W-1:2], 2'b00};
                    sel_d  = sel_calc;
                    dat_d  = wdat_calc;
                    we_d   = (op_q == STORE_DATA);
                    bcyc_d = 1'b1;
`ifdef MAU_TIMEOUT_EN
                    cnt_d  = '0;
`endif
                end
            end
            S_BUS: begin
`ifdef MAU_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (bus_fail) begin
                    bcyc_d = 1'b0;
                    we_d   = 1'b0;
                    err_d  = 1'b1;
                end else if (wb_ack_i) begin
                    bcyc_d  = 1'b0;
                    we_d    = 1'b0;
                    rdata_d = wb_dat_i;
                end
            end
            S_RESP: begin
                done_d = 1'b1;
                if (op_q != STORE_DATA) begin
                    dv_d      = 1'b1;
                    fetched_d = rd_ext;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= MEM_NONE;
            f3_q      <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            rdata_q   <= '0;
            fetched_q <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            bcyc_q    <= 1'b0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
`ifdef MAU_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            f3_q      <= f3_d;
            addr_q    <= addr_d;
            sdata_q   <= sdata_d;
            rdata_q   <= rdata_d;
            fetched_q <= fetched_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            bcyc_q    <= bcyc_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
`ifdef MAU_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign ack          = ack_q;
    assign done         = done_q;
    assign data_valid   = dv_q;
    assign err          = err_q;
    assign fetched_data = fetched_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign wb_we_o      = we_q;
    assign wb_cyc_o     = bcyc_q;
    assign wb_stb_o     = bcyc_q;

endmodule
